ex_md_stage: RTL
================

EX_MD_STAGE -- requirements
Module: ex_md_stage

Interface
REQ-001 Parameter XLEN, 32, datapath width in bits (32 or 64).
REQ-002 Parameter EN_MD, 1, 1 enables multiply/divide unit; 0 makes block purely combinational, MDValid_ex ignored, stall_ex tied 0.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  reset; one clock; reset is synchronous and active-low.
REQ-005 ALUCode_ex  in  4  ALU operation, existing ALU encoding.
REQ-006 MDValid_ex  in  1  instruction in EX is an M-extension op.
REQ-007 MDCode_ex  in  3  RV M funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-008 ALUSrcA_ex  in  1  0 = forwarded rs1, 1 = PC_ex; ALUSrcB_ex  in  2  0 = forwarded rs2, 1 = Imm_ex, 2 = constant 4.
REQ-009 Imm_ex, PC_ex, rs1Data_ex, rs2Data_ex, RegWriteData_wb, ALUResult_mem  in  XLEN each  operand and forwarding sources.
REQ-010 rs1Addr_ex, rs2Addr_ex, rdAddr_mem, rdAddr_wb  in  5 each; RegWrite_mem, RegWrite_wb  in  1 each.
REQ-011 flush_ex  in  1  kill instruction in EX.
REQ-012 Result_ex  out  XLEN; MemWriteData_ex  out  XLEN (forwarded rs2); stall_ex  out  1  hold IF/ID/EX, bubble into MEM.

Function
REQ-013 Forwarding per operand: MEM match (RegWrite_mem, rdAddr_mem != 0, equal address) wins over WB match; else register-file data; x0 never forwarded.
REQ-014 MDValid_ex = 0: Result_ex = ALU(A, B) combinationally, zero latency, stall_ex = 0.
REQ-015 FSM states IDLE, BUSY, DONE; IDLE→BUSY when MDValid_ex & !flush_ex; BUSY→DONE when step counter reaches XLEN-1; DONE→IDLE unconditionally.
REQ-016 On IDLE→BUSY edge, forwarded rs1/rs2 and MDCode_ex captured into internal registers; later forwarding-source changes do not affect the result.
REQ-017 stall_ex = 1 combinationally in IDLE when MDValid_ex & !flush_ex, and throughout BUSY; 0 in DONE; total stall = XLEN+1 cycles per M op.
REQ-018 Iterative radix-2: one shift-add (multiply) or restoring-subtract (divide) step per BUSY cycle, step counter 0..XLEN-1, wraps to 0 on exit.
REQ-019 Signed ops by sign-magnitude: operands made magnitudes at capture, result sign fixed in DONE; MULHSU treats rs2 unsigned.
REQ-020 MUL returns low XLEN bits of 2*XLEN product; MULH* return high XLEN bits.
REQ-021 Divide by zero: quotient all ones, remainder = dividend; signed overflow (MIN / -1): quotient MIN, remainder 0; both still take full latency.
REQ-022 Result_ex = M result in DONE; 0 during BUSY and during IDLE stall cycle.
REQ-023 flush_ex in any state → IDLE next cycle, stall_ex deasserts same cycle, partial result discarded.
REQ-024 MDValid_ex in DONE does not restart (same instruction still held).

Reset
REQ-025 rst_n low at clk edge: state IDLE, counter 0, all operand/accumulator registers 0, stall_ex 0, Result_ex follows REQ-014.
REQ-026 Reset mid-BUSY aborts operation identically to flush, no result produced.

Structure
REQ-027 Shared package holds FSM state enum, MDCode_ex encodings, ALUSrcB select constants.
REQ-028 One sub-module md_iter (FSM, counter, iterative datapath); forwarding muxes and ALU instantiation stay in ex_md_stage.

Verification
REQ-029 ADD, rs1Addr_ex = rdAddr_mem = 5, RegWrite_mem = 1, ALUResult_mem = 7, rdAddr_wb = 5 with 9, rs2 = 3 → Result_ex = 10, no stall.
REQ-030 MUL 0xFFFFFFFF × 2 (XLEN=32) → stall 33 cycles, DONE Result_ex = 0xFFFFFFFE; MULHU same operands → 0x00000001.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same → 0; DIVU 7/0 → 0xFFFFFFFF; REMU 7/0 → 7.
REQ-032 DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; change ALUResult_mem during BUSY → result unchanged.
REQ-033 flush_ex at BUSY step 10 → stall_ex 0 same cycle, IDLE next; following ADD completes with zero latency.
REQ-034 rst_n low at BUSY step 5 → IDLE, stall_ex 0; EN_MD = 0 build with MDValid_ex = 1 → never stalls.

Source files
------------

// File: rtl/ex_md_stage_pkg.sv
// Shared types and encodings for the EX stage with its iterative multiply/divide unit.
package ex_md_stage_pkg;

  // Multiply/divide sequencer states
  typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_e;

  // RV32M/RV64M funct3 encodings
  localparam logic [2:0] MdMul    = 3'd0;
  localparam logic [2:0] MdMulh   = 3'd1;
  localparam logic [2:0] MdMulhsu = 3'd2;
  localparam logic [2:0] MdMulhu  = 3'd3;
  localparam logic [2:0] MdDiv    = 3'd4;
  localparam logic [2:0] MdDivu   = 3'd5;
  localparam logic [2:0] MdRem    = 3'd6;
  localparam logic [2:0] MdRemu   = 3'd7;

  // ALU operand B select
  localparam logic [1:0] SrcBRs2  = 2'd0;
  localparam logic [1:0] SrcBImm  = 2'd1;
  localparam logic [1:0] SrcBFour = 2'd2;

  // ALU operation codes
  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluSll  = 4'd2;
  localparam logic [3:0] AluSlt  = 4'd3;
  localparam logic [3:0] AluSltu = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluOr   = 4'd8;
  localparam logic [3:0] AluAnd  = 4'd9;
  localparam logic [3:0] AluLui  = 4'd10;

  // funct3[2] separates the divide family from the multiply family
  function automatic logic md_is_div(input logic [2:0] code);
    return code[2];
  endfunction

endpackage

// File: rtl/ex_md_stage_if.sv
// EX-stage operand, forwarding and result bundle.
interface ex_md_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic [3:0]      ALUCode_ex;
  logic            MDValid_ex;
  logic [2:0]      MDCode_ex;
  logic            ALUSrcA_ex;
  logic [1:0]      ALUSrcB_ex;
  logic [XLEN-1:0] Imm_ex;
  logic [XLEN-1:0] PC_ex;
  logic [XLEN-1:0] rs1Data_ex;
  logic [XLEN-1:0] rs2Data_ex;
  logic [XLEN-1:0] RegWriteData_wb;
  logic [XLEN-1:0] ALUResult_mem;
  logic [4:0]      rs1Addr_ex;
  logic [4:0]      rs2Addr_ex;
  logic [4:0]      rdAddr_mem;
  logic [4:0]      rdAddr_wb;
  logic            RegWrite_mem;
  logic            RegWrite_wb;
  logic            flush_ex;
  logic [XLEN-1:0] Result_ex;
  logic [XLEN-1:0] MemWriteData_ex;
  logic            stall_ex;

  modport master (
    output ALUCode_ex, MDValid_ex, MDCode_ex, ALUSrcA_ex, ALUSrcB_ex, Imm_ex, PC_ex,
           rs1Data_ex, rs2Data_ex, RegWriteData_wb, ALUResult_mem, rs1Addr_ex, rs2Addr_ex,
           rdAddr_mem, rdAddr_wb, RegWrite_mem, RegWrite_wb, flush_ex,
    input  Result_ex, MemWriteData_ex, stall_ex
  );

  modport slave (
    input  ALUCode_ex, MDValid_ex, MDCode_ex, ALUSrcA_ex, ALUSrcB_ex, Imm_ex, PC_ex,
           rs1Data_ex, rs2Data_ex, RegWriteData_wb, ALUResult_mem, rs1Addr_ex, rs2Addr_ex,
           rdAddr_mem, rdAddr_wb, RegWrite_mem, RegWrite_wb, flush_ex,
    output Result_ex, MemWriteData_ex, stall_ex
  );
endinterface

// File: rtl/ex_md_stage_md_iter.sv
// Radix-2 iterative multiply/divide: sign-magnitude operands, one step per BUSY cycle.
module md_iter
  import ex_md_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      md_code,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            stall,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

  md_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // acc: product high half / partial remainder; mq: multiplier+product low half / quotient
  logic [XLEN-1:0]   acc_q, acc_d, mq_q, mq_d, mcand_q, mcand_d;
  logic [2:0]        code_q, code_d;
  logic              neg_q, neg_d, neg_rem_q, neg_rem_d;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     sum, rem_sh, diff;
  logic [2*XLEN-1:0] prod_s;

  // Operand magnitudes and a single shared step datapath
  always_comb begin
    a_neg  = op_a[XLEN-1] & (md_code inside {MdMulh, MdMulhsu, MdDiv, MdRem});
    b_neg  = op_b[XLEN-1] & (md_code inside {MdMulh, MdDiv, MdRem});
    a_mag  = a_neg ? -op_a : op_a;
    b_mag  = b_neg ? -op_b : op_b;
    sum    = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : '0);
    rem_sh = {acc_q, mq_q[XLEN-1]};
    diff   = rem_sh - {1'b0, mcand_q};
  end

  // Sequencer next state, capture and per-step update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    mcand_d   = mcand_q;
    code_d    = code_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    stall     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          stall     = 1'b1;
          state_d   = StBusy;
          cnt_d     = '0;
          acc_d     = '0;
          mq_d      = a_mag;
          mcand_d   = b_mag;
          code_d    = md_code;
          // Divide by zero must yield all ones regardless of dividend sign
          neg_d     = (a_neg ^ b_neg) & ~(md_is_div(md_code) & (op_b == '0));
          neg_rem_d = a_neg;
        end
      end
      StBusy: begin
        stall = 1'b1;
        if (md_is_div(code_q)) begin
          if (!diff[XLEN]) begin
            acc_d = diff[XLEN-1:0];
            mq_d  = {mq_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = rem_sh[XLEN-1:0];
            mq_d  = {mq_q[XLEN-2:0], 1'b0};
          end
        end else begin
          acc_d = sum[XLEN:1];
          mq_d  = {sum[0], mq_q[XLEN-1:1]};
        end
        if (cnt_q == CntLast) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
      stall   = 1'b0;
    end
  end

  // Sign fix-up and result select, only presented in DONE
  always_comb begin
    prod_s = neg_q ? -{acc_q, mq_q} : {acc_q, mq_q};
    result = '0;
    if (state_q == StDone) begin
      unique case (code_q)
        MdMul:                    result = prod_s[XLEN-1:0];
        MdMulh, MdMulhsu, MdMulhu: result = prod_s[2*XLEN-1:XLEN];
        MdDiv, MdDivu:            result = neg_q ? -mq_q : mq_q;
        default:                  result = neg_rem_q ? -acc_q : acc_q;
      endcase
    end
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      mcand_q   <= '0;
      code_q    <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      mcand_q   <= mcand_d;
      code_q    <= code_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule

// File: rtl/ex_md_stage.sv
// EX stage: operand forwarding, ALU and optional iterative multiply/divide unit.
module ex_md_stage
  import ex_md_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter bit          EN_MD = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  ex_md_stage_if.slave bus
);

  localparam int unsigned ShW = $clog2(XLEN);

  logic [XLEN-1:0] fwd_a, fwd_b, alu_a, alu_b, alu_result, md_result;
  logic [ShW-1:0]  shamt;
  logic            md_stall, md_sel;

  // Forwarding: MEM beats WB, x0 is never forwarded
  always_comb begin
    fwd_a = bus.rs1Data_ex;
    if (bus.RegWrite_mem && bus.rdAddr_mem != '0 && bus.rdAddr_mem == bus.rs1Addr_ex) begin
      fwd_a = bus.ALUResult_mem;
    end else if (bus.RegWrite_wb && bus.rdAddr_wb != '0 && bus.rdAddr_wb == bus.rs1Addr_ex) begin
      fwd_a = bus.RegWriteData_wb;
    end
    fwd_b = bus.rs2Data_ex;
    if (bus.RegWrite_mem && bus.rdAddr_mem != '0 && bus.rdAddr_mem == bus.rs2Addr_ex) begin
      fwd_b = bus.ALUResult_mem;
    end else if (bus.RegWrite_wb && bus.rdAddr_wb != '0 && bus.rdAddr_wb == bus.rs2Addr_ex) begin
      fwd_b = bus.RegWriteData_wb;
    end
  end

  // ALU operand selection and operation
  always_comb begin
    alu_a = bus.ALUSrcA_ex ? bus.PC_ex : fwd_a;
    case (bus.ALUSrcB_ex)
      SrcBImm:  alu_b = bus.Imm_ex;
      SrcBFour: alu_b = XLEN'(4);
      default:  alu_b = fwd_b;
    endcase
    shamt      = alu_b[ShW-1:0];
    alu_result = '0;
    case (bus.ALUCode_ex)
      AluAdd:  alu_result = alu_a + alu_b;
      AluSub:  alu_result = alu_a - alu_b;
      AluSll:  alu_result = alu_a << shamt;
      AluSlt:  alu_result = XLEN'($signed(alu_a) < $signed(alu_b));
      AluSltu: alu_result = XLEN'(alu_a < alu_b);
      AluXor:  alu_result = alu_a ^ alu_b;
      AluSrl:  alu_result = alu_a >> shamt;
      AluSra:  alu_result = $unsigned($signed(alu_a) >>> shamt);
      AluOr:   alu_result = alu_a | alu_b;
      AluAnd:  alu_result = alu_a & alu_b;
      AluLui:  alu_result = alu_b;
      default: alu_result = '0;
    endcase
  end

  if (EN_MD) begin : g_md
    md_iter #(
      .XLEN(XLEN)
    ) u_md_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (bus.MDValid_ex & ~bus.flush_ex),
      .flush  (bus.flush_ex),
      .md_code(bus.MDCode_ex),
      .op_a   (fwd_a),
      .op_b   (fwd_b),
      .stall  (md_stall),
      .result (md_result)
    );
    assign md_sel = bus.MDValid_ex;
  end else begin : g_no_md
    assign md_stall  = 1'b0;
    assign md_result = '0;
    assign md_sel    = 1'b0;
  end

  assign bus.Result_ex       = md_sel ? md_result : alu_result;
  assign bus.MemWriteData_ex = fwd_b;
  assign bus.stall_ex        = md_stall;

endmodule
